// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned JIDX_W    = 26;
  localparam int unsigned REGION_W  = 4;
  localparam int unsigned CNT_W     = 16;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'd0,
    PCSEL_BR  = 2'd1,
    PCSEL_J   = 2'd2,
    PCSEL_JR  = 2'd3
  } pcsel_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  // J-type target: upper region of PC+4, 26-bit word index, word aligned.
  function automatic logic [XLEN-1:0] jump_target(
    input logic [REGION_W-1:0] region,
    input logic [JIDX_W-1:0]   index
  );
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_select.sv
// Next-PC priority select (JR > J > branch > sequential) and PC load enable.
module pc_select
  import mips_pkg::*;
(
  input  logic [XLEN-1:0]     pc,
  input  logic [REGION_W-1:0] region,
  input  logic [JIDX_W-1:0]   jump_index,
  input  logic [XLEN-1:0]     branch_target,
  input  logic [XLEN-1:0]     jr_target,
  input  logic                src_pc,
  input  logic                jump,
  input  logic                jreg,
  input  logic                write_pc,
  output logic [XLEN-1:0]     pc_plus4_c,
  output logic [XLEN-1:0]     next_pc_c,
  output logic                redirect_c,
  output logic                pc_load_c
);

  pcsel_e sel;

  assign pc_plus4_c = pc + XLEN'(4);

  always_comb begin
    sel = PCSEL_SEQ;
    if (jreg) begin
      sel = PCSEL_JR;
    end else if (jump) begin
      sel = PCSEL_J;
    end else if (src_pc) begin
      sel = PCSEL_BR;
    end
  end

  always_comb begin
    next_pc_c = pc_plus4_c;
    unique case (sel)
      PCSEL_JR:  next_pc_c = jr_target;
      PCSEL_J:   next_pc_c = jump_target(region, jump_index);
      PCSEL_BR:  next_pc_c = branch_target;
      default:   next_pc_c = pc_plus4_c;
    endcase
  end

  // Redirects override a load-use stall on the PC.
  assign redirect_c = jreg | jump | src_pc;
  assign pc_load_c  = redirect_c | write_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register, optional perf
// counters enabled by FETCH_PERF_CNT_EN.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            writePCounter,
  input  logic            writeIfId,
  input  logic            flushIfId,
  input  logic            SRCPCounter,
  input  logic            Jump,
  input  logic            JRegister,
  input  logic [XLEN-1:0] branchTarget,
  input  logic [XLEN-1:0] jrTarget,
  output logic [XLEN-1:0] imemAddr,
  input  logic [XLEN-1:0] imemData,
  output logic [XLEN-1:0] instrIfId,
  output logic [XLEN-1:0] pcPlus4IfId,
`ifdef FETCH_PERF_CNT_EN
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
`endif
  output logic            validIfId
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            pc_load;
  ifid_t           ifid;

  pc_select u_pc_select (
    .pc            (pc),
    .region        (ifid.pc_plus4[XLEN-1 -: REGION_W]),
    .jump_index    (ifid.instr[JIDX_W-1:0]),
    .branch_target (branchTarget),
    .jr_target     (jrTarget),
    .src_pc        (SRCPCounter),
    .jump          (Jump),
    .jreg          (JRegister),
    .write_pc      (writePCounter),
    .pc_plus4_c    (pc_plus4),
    .next_pc_c     (next_pc),
    .redirect_c    (redirect),
    .pc_load_c     (pc_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (pc_load) begin
      pc <= next_pc;
    end
  end

  // Flush beats write enable; flushed slot carries a NOP bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
    end else if (flushIfId) begin
      ifid <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
    end else if (writeIfId) begin
      ifid <= '{instr: imemData, pc_plus4: pc_plus4, valid: 1'b1};
    end
  end

  assign imemAddr    = pc;
  assign instrIfId   = ifid.instr;
  assign pcPlus4IfId = ifid.pc_plus4;
  assign validIfId   = ifid.valid;

`ifdef FETCH_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating event counters; a redirected cycle is not a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!writePCounter && !redirect && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flushIfId && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stallCount = stall_cnt;
  assign flushCount = flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem word at address a is 32'hA000_0000 | a[31:2].
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        writePCounter, writeIfId, flushIfId;
  logic        SRCPCounter, Jump, JRegister;
  logic [31:0] branchTarget, jrTarget;
  logic [31:0] imemAddr, imemData, instrIfId, pcPlus4IfId;
  logic        validIfId;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stallCount, flushCount;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign imemData = 32'hA000_0000 | {2'b00, imemAddr[31:2]};

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .writePCounter (writePCounter),
    .writeIfId     (writeIfId),
    .flushIfId     (flushIfId),
    .SRCPCounter   (SRCPCounter),
    .Jump          (Jump),
    .JRegister     (JRegister),
    .branchTarget  (branchTarget),
    .jrTarget      (jrTarget),
    .imemAddr      (imemAddr),
    .imemData      (imemData),
    .instrIfId     (instrIfId),
    .pcPlus4IfId   (pcPlus4IfId),
`ifdef FETCH_PERF_CNT_EN
    .stallCount    (stallCount),
    .flushCount    (flushCount),
`endif
    .validIfId     (validIfId)
  );

  task automatic idle();
    writePCounter = 1'b1; writeIfId = 1'b1; flushIfId = 1'b0;
    SRCPCounter = 1'b0; Jump = 1'b0; JRegister = 1'b0;
    branchTarget = 32'h0; jrTarget = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] addr,
                     input logic [31:0] instr, input logic [31:0] pc4,
                     input logic valid);
    tests++;
    assert (imemAddr === addr) else begin
      fails++; $error("FAIL %s.addr got %h expected %h", tag, imemAddr, addr);
    end
    tests++;
    assert (instrIfId === instr) else begin
      fails++; $error("FAIL %s.instr got %h expected %h", tag, instrIfId, instr);
    end
    tests++;
    assert (pcPlus4IfId === pc4) else begin
      fails++; $error("FAIL %s.pc4 got %h expected %h", tag, pcPlus4IfId, pc4);
    end
    tests++;
    assert (validIfId === valid) else begin
      fails++; $error("FAIL %s.valid got %b expected %b", tag, validIfId, valid);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic chk_cnt(input string tag, input logic [15:0] st, input logic [15:0] fl);
    tests++;
    assert (stallCount === st) else begin
      fails++; $error("FAIL %s.stall got %0d expected %0d", tag, stallCount, st);
    end
    tests++;
    assert (flushCount === fl) else begin
      fails++; $error("FAIL %s.flush got %0d expected %0d", tag, flushCount, fl);
    end
  endtask
`endif

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    chk("reset", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk_cnt("reset_cnt", 16'd0, 16'd0);
`endif
    #1 rst_n = 1'b1;

    // free run
    tick(); chk("run1", 32'h4,  32'hA000_0000, 32'h4,  1'b1);
    tick(); chk("run2", 32'h8,  32'hA000_0001, 32'h8,  1'b1);
    tick(); chk("run3", 32'hC,  32'hA000_0002, 32'hC,  1'b1);

    // branch back to 4 with flush
    SRCPCounter = 1'b1; branchTarget = 32'h4; flushIfId = 1'b1;
    tick(); chk("br4", 32'h4, 32'h0, 32'h0, 1'b0);
    idle();
    tick(); chk("br4_next", 32'h8, 32'hA000_0001, 32'h8, 1'b1);

    // load-use stall at PC = 8
    writePCounter = 1'b0; writeIfId = 1'b0;
    tick(); chk("stall", 32'h8, 32'hA000_0001, 32'h8, 1'b1);
    idle();
    tick(); chk("resume", 32'hC, 32'hA000_0002, 32'hC, 1'b1);

    // taken branch to 0x40
    SRCPCounter = 1'b1; branchTarget = 32'h40; flushIfId = 1'b1;
    tick(); chk("br40", 32'h40, 32'h0, 32'h0, 1'b0);
    idle();
    tick(); chk("br40_next", 32'h44, 32'hA000_0010, 32'h44, 1'b1);

    // jr beats branch; redirect beats stall; flush beats writeIfId=0
    Jump = 1'b1; JRegister = 1'b1; jrTarget = 32'h100;
    SRCPCounter = 1'b1; branchTarget = 32'h40; flushIfId = 1'b1;
    writePCounter = 1'b0; writeIfId = 1'b0;
    tick(); chk("jr", 32'h100, 32'h0, 32'h0, 1'b0);
    idle();
    tick(); chk("jr_next", 32'h104, 32'hA000_0040, 32'h104, 1'b1);

    // j: {pc4[31:28], instr[25:0], 00} = 0x100; beats branch
    Jump = 1'b1; jrTarget = 32'h200; SRCPCounter = 1'b1; branchTarget = 32'h40;
    flushIfId = 1'b1;
    tick(); chk("j", 32'h100, 32'h0, 32'h0, 1'b0);
    idle();

    // wrap at top of address space
    Jump = 1'b1; JRegister = 1'b1; jrTarget = 32'hFFFF_FFFC; flushIfId = 1'b1;
    tick(); chk("jr_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    idle();
    tick(); chk("wrap", 32'h0, 32'hBFFF_FFFF, 32'h0, 1'b1);

    // misaligned target passes through
    Jump = 1'b1; JRegister = 1'b1; jrTarget = 32'h103; flushIfId = 1'b1;
    tick(); chk("jr_mis", 32'h103, 32'h0, 32'h0, 1'b0);
    idle();
    tick(); chk("mis_next", 32'h107, 32'hA000_0040, 32'h107, 1'b1);

    // plain flush with writeIfId = 0
    flushIfId = 1'b1; writeIfId = 1'b0;
    tick(); chk("flush_only", 32'h10B, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk_cnt("cnt_pre_rst", 16'd1, 16'd7);
`endif
    idle();
    tick(); chk("post_flush", 32'h10F, 32'hA000_0042, 32'h10F, 1'b1);

    // async reset mid-cycle during a stall
    writePCounter = 1'b0; writeIfId = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk_cnt("async_rst_cnt", 16'd0, 16'd0);
`endif
    idle();
    #1 rst_n = 1'b1;
    tick(); chk("after_rst", 32'h4, 32'hA000_0000, 32'h4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
